// File: rtl/nested_top_burst_sink.sv
// nested_top_burst_sink: receive end of the burst link.
// Packs up to BEATS stream beats into one wide word for a req/ack consumer.
package hierIncludeNestedTop_package;
  localparam int YET_ANOTHER_SIZE = 8;
endpackage

module nested_top_burst_sink
  import hierIncludeNestedTop_package::*;
#(
  parameter int DATA_W = 8,
  parameter int BEATS  = YET_ANOTHER_SIZE,
  parameter int CNT_W  = $clog2(BEATS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_vld,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_last,
  output logic                      in_rdy,
  output logic                      out_req,
  output logic [DATA_W*BEATS-1:0]   out_data,
  output logic [CNT_W-1:0]          out_count,
  output logic                      out_err,
  input  logic                      out_ack
);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

  logic [0:0]              state_q;
  logic [CNT_W-1:0]        idx_q;
  logic [DATA_W*BEATS-1:0] pack_q;
  logic [CNT_W-1:0]        count_q;
  logic                    err_q;

  logic take;
  logic close;
  logic ack;

  // Beat acceptance, burst close and consumer handshake decode.
  always_comb begin
    take  = in_vld & (state_q == COLLECT);
    close = take & (in_last | (idx_q == LAST_IDX));
    ack   = out_ack & (state_q == HOLD);
  end

  // Control: state, lane index, reported count and truncation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (close) begin
            state_q <= HOLD;
            idx_q   <= '0;
            count_q <= idx_q + CNT_W'(1);
            err_q   <= ~in_last;
          end else if (take) begin
            idx_q <= idx_q + CNT_W'(1);
          end
        end
        HOLD: begin
          if (ack) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  // Packing buffer: write the current lane, wipe all lanes on handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q <= '0;
    end else if (ack) begin
      pack_q <= '0;
    end else if (take) begin
      pack_q[idx_q*DATA_W +: DATA_W] <= in_data;
    end
  end

  assign in_rdy    = (state_q == COLLECT);
  assign out_req   = (state_q == HOLD);
  assign out_data  = pack_q;
  assign out_count = count_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_nested_top_burst_sink.sv
// tb_nested_top_burst_sink: directed and randomized checks
// of burst packing, truncation, backpressure and reset.
module tb_nested_top_burst_sink;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_vld = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        in_rdy;
  logic        out_req;
  logic [63:0] out_data;
  logic [3:0]  out_count;
  logic        out_err;
  logic        out_ack = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  nested_top_burst_sink dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld    (in_vld),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_rdy    (in_rdy),
    .out_req   (out_req),
    .out_data  (out_data),
    .out_count (out_count),
    .out_err   (out_err),
    .out_ack   (out_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Called and returns at a negedge; beat is taken at the posedge between.
  task automatic send_beat(input logic [7:0] d, input logic l);
    int n = 0;
    in_vld  = 1'b1;
    in_data = d;
    in_last = l;
    while (!in_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_rdy) chk("rdy_timeout", 64'd0, 64'd1);
    @(negedge clk);
    in_vld  = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic get_burst(input string tag, input logic [63:0] ed,
                           input logic [3:0] ec, input logic ee,
                           input int dly);
    int n = 0;
    while (!out_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, 64'(out_req), 64'd1);
    repeat (dly) @(negedge clk);
    chk({tag, "_data"}, out_data, ed);
    chk({tag, "_cnt"}, 64'(out_count), 64'(ec));
    chk({tag, "_err"}, 64'(out_err), 64'(ee));
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
    chk({tag, "_rdy_after_ack"}, 64'(in_rdy), 64'd1);
    chk({tag, "_req_after_ack"}, 64'(out_req), 64'd0);
  endtask

  initial begin
    logic [63:0] exp_d;
    int len, lane, base;
    logic [7:0] d;

    #1 chk("rst_rdy", 64'(in_rdy), 64'd1);
    chk("rst_req", 64'(out_req), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_cnt", 64'(out_count), 64'd0);
    chk("rst_err", 64'(out_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: reset in the middle of a burst discards it
    send_beat(8'h31, 1'b0);
    send_beat(8'h32, 1'b0);
    send_beat(8'h33, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t1_req", 64'(out_req), 64'd0);
    chk("t1_rdy", 64'(in_rdy), 64'd1);
    chk("t1_data", out_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_beat(8'hA5, 1'b1);
    get_burst("t1", 64'h00000000000000A5, 4'd1, 1'b0, 0);

    // 2: full burst closed by in_last on beat 8
    for (int i = 1; i <= 7; i++) send_beat(8'(i * 17), 1'b0);
    chk("t2_req_early", 64'(out_req), 64'd0);
    send_beat(8'h88, 1'b1);
    chk("t2_req_next", 64'(out_req), 64'd1);
    chk("t2_rdy_low", 64'(in_rdy), 64'd0);
    repeat (3) @(negedge clk);
    chk("t2_rdy_hold", 64'(in_rdy), 64'd0);
    get_burst("t2", 64'h8877665544332211, 4'd8, 1'b0, 0);

    // 3+4: truncation at 8 beats, then backpressure on beat 9
    for (int i = 1; i <= 8; i++) send_beat(8'(i), 1'b0);
    in_vld  = 1'b1;
    in_data = 8'h09;
    in_last = 1'b0;
    repeat (20) @(negedge clk);
    chk("t4_rdy_bp", 64'(in_rdy), 64'd0);
    chk("t3_data", out_data, 64'h0807060504030201);
    chk("t3_cnt", 64'(out_count), 64'd8);
    chk("t3_err", 64'(out_err), 64'd1);
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
    chk("t4_rdy_after_ack", 64'(in_rdy), 64'd1);
    @(negedge clk);
    in_vld = 1'b0;
    send_beat(8'h0A, 1'b1);
    get_burst("t3b", 64'h0000000000000A09, 4'd2, 1'b0, 1);

    // 6: short bursts back to back, stale lanes must read zero
    send_beat(8'hC1, 1'b0);
    send_beat(8'hC2, 1'b0);
    send_beat(8'hC3, 1'b1);
    get_burst("t6a", 64'h0000000000C3C2C1, 4'd3, 1'b0, 0);
    send_beat(8'hD1, 1'b1);
    get_burst("t6b", 64'h00000000000000D1, 4'd1, 1'b0, 0);
    for (int i = 1; i <= 4; i++) send_beat(8'(8'hE0 + i), 1'b0);
    send_beat(8'hE5, 1'b1);
    get_burst("t6c", 64'h000000E5E4E3E2E1, 4'd5, 1'b0, 0);

    // 5: random bursts of 1..10 beats with gaps and stray acks
    for (int b = 0; b < 1000; b++) begin
      len   = $urandom_range(1, 10);
      exp_d = '0;
      lane  = 0;
      base  = 0;
      for (int k = 0; k < len; k++) begin
        repeat ($urandom_range(0, 2)) begin
          out_ack = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        out_ack = 1'b0;
        d = 8'($urandom_range(0, 255));
        send_beat(d, 1'(k == len - 1));
        exp_d[lane*8 +: 8] = d;
        lane++;
        if (k == len - 1 || lane == 8) begin
          get_burst("rnd", exp_d, 4'(lane),
                    1'(lane == 8 && k != len - 1),
                    $urandom_range(0, 3));
          exp_d = '0;
          lane  = 0;
          base  = k + 1;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
